// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - execute-stage sequencer for the 12-bit ALU, owns flags {P,V,K,S,Z}
// Optional multi-pass repeat for ops 0x08-0x0F is built only when ALU_REPEAT_EN is defined.
module alu_sequencer #(
  parameter int WIDTH  = 12,
  parameter int FLAG_W = 5,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [3:0]        in_cond,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [CNT_W-1:0]  in_count,
  input  logic              in_pred,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [4:0]        alu_op,
  output logic [3:0]        alu_cond,
  output logic [FLAG_W-1:0] alu_flg_in,
  input  logic [WIDTH-1:0]  alu_q,
  input  logic [FLAG_W-1:0] alu_flg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_q,
  output logic              out_squashed,
  output logic [FLAG_W-1:0] flags,
  input  logic              flg_load,
  input  logic [FLAG_W-1:0] flg_load_value
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state;
  state_t            state_nx;
  logic [4:0]        op_r;
  logic [3:0]        cond_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  work_b;
  logic [FLAG_W-1:0] work_flg;
  logic [WIDTH-1:0]  q_r;
  logic              squash_r;
  logic [FLAG_W-1:0] flags_r;
  logic              accept;
  logic              pred_fail;
  logic              last_pass;

  // P lives in the top flag bit; predicate is tested against the pre-load value
  assign accept    = in_valid && (state == IDLE);
  assign pred_fail = in_pred && !flags_r[FLAG_W-1];

`ifdef ALU_REPEAT_EN
  logic [CNT_W-1:0] cnt_r;
  assign last_pass = (cnt_r == '0);
`else
  logic unused_count;
  assign unused_count = ^in_count;
  assign last_pass    = 1'b1;
`endif

  assign out_q        = q_r;
  assign out_squashed = squash_r;
  assign flags        = flags_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake/ALU-drive outputs; ALU inputs are zero outside EXEC
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    alu_cond   = '0;
    alu_flg_in = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = pred_fail ? DONE : EXEC;
      end
      EXEC: begin
        alu_a      = a_r;
        alu_b      = work_b;
        alu_op     = op_r;
        alu_cond   = cond_r;
        alu_flg_in = work_flg;
        if (last_pass) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, pass feedback, result/flag commit and external flag load
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= '0;
      cond_r   <= '0;
      a_r      <= '0;
      work_b   <= '0;
      work_flg <= '0;
      q_r      <= '0;
      squash_r <= 1'b0;
      flags_r  <= '0;
`ifdef ALU_REPEAT_EN
      cnt_r    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (flg_load) flags_r <= flg_load_value;
          if (accept) begin
            op_r     <= in_op;
            cond_r   <= in_cond;
            a_r      <= in_a;
            work_b   <= in_b;
            work_flg <= flags_r;
`ifdef ALU_REPEAT_EN
            // only shift/rotate class ops (0x08-0x0F) may repeat
            cnt_r    <= (in_op[4:3] == 2'b01) ? in_count : '0;
`endif
            if (pred_fail) begin
              q_r      <= '0;
              squash_r <= 1'b1;
            end
          end
        end
        EXEC: begin
          work_b   <= alu_q;
          work_flg <= alu_flg;
          if (last_pass) begin
            q_r      <= alu_q;
            flags_r  <= alu_flg;
            squash_r <= 1'b0;
          end
`ifdef ALU_REPEAT_EN
          else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [3:0]  in_cond;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic [3:0]  in_count;
  logic        in_pred;
  logic [11:0] alu_a;
  logic [11:0] alu_b;
  logic [4:0]  alu_op;
  logic [3:0]  alu_cond;
  logic [4:0]  alu_flg_in;
  logic [11:0] alu_q;
  logic [4:0]  alu_flg;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_q;
  logic        out_squashed;
  logic [4:0]  flags;
  logic        flg_load;
  logic [4:0]  flg_load_value;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] m_flags;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_a(in_a), .in_b(in_b),
    .in_count(in_count), .in_pred(in_pred),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cond(alu_cond),
    .alu_flg_in(alu_flg_in), .alu_q(alu_q), .alu_flg(alu_flg),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_squashed(out_squashed), .flags(flags),
    .flg_load(flg_load), .flg_load_value(flg_load_value)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {q[11:0], P, V, K, S, Z}
  function automatic logic [16:0] alu_f(input logic [4:0] op, input logic [3:0] cond,
                                        input logic [11:0] a, input logic [11:0] b,
                                        input logic [4:0] fi);
    logic [12:0] s;
    logic [11:0] q;
    logic k, v, p;
    logic [3:0] f;
    k = 1'b0; v = 1'b0; s = '0;
    case (op)
      5'h00: q = a & b;
      5'h01: q = a | b;
      5'h02: q = a ^ b;
      5'h03: begin s = {1'b0, a} - {1'b0, b}; q = s[11:0]; k = s[12];
                   v = (a[11] != b[11]) && (q[11] != a[11]); end
      5'h04: begin s = {1'b0, a} + {1'b0, b}; q = s[11:0]; k = s[12];
                   v = (a[11] == b[11]) && (q[11] != a[11]); end
      5'h08: begin q = {1'b0, b[11:1]}; k = b[0]; end
      5'h09: begin q = {b[0], b[11:1]}; k = b[0]; end
      5'h0A: begin q = {b[10:0], b[11]}; k = b[11]; end
      5'h0B: begin q = {b[11], b[11:1]}; k = b[0]; end
      5'h0C: begin q = {b[10:0], 1'b0}; k = b[11]; end
      5'h0D, 5'h0E, 5'h0F: begin q = b + 12'd1; k = (b == 12'hFFF); end
      default: q = a;
    endcase
    f = {v, k, q[11], (q == 12'd0)};
    p = cond[3] ? f[cond[1:0]] : (cond[0] ? ~fi[4] : fi[4]);
    return {q, p, f};
  endfunction

  always_comb {alu_q, alu_flg} = alu_f(alu_op, alu_cond, alu_a, alu_b, alu_flg_in);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_flags(input logic [4:0] v);
    flg_load = 1'b1; flg_load_value = v;
    @(posedge clk); #1;
    flg_load = 1'b0;
    m_flags = v;
    check("flg_load", flags, v);
  endtask

  // Issue one op, predict everything from the ALU rules, and compare
  task automatic run_op(input logic [4:0] op, input logic [3:0] cond, input logic [11:0] a,
                        input logic [11:0] b, input logic [3:0] cnt, input logic pred,
                        input logic ld, input logic [4:0] ldv, input int hold);
    logic [11:0] exp_b[$];
    logic [11:0] bw, exp_q, q_hold;
    logic [4:0]  fw, f_hold;
    logic [16:0] r;
    logic        exp_sq;
    int ec, exp_n, n;
    ec = 0;
`ifdef ALU_REPEAT_EN
    if (op >= 5'h08 && op <= 5'h0F) ec = int'(cnt);
`endif
    if (pred && !m_flags[4]) begin
      exp_q = 12'd0; exp_sq = 1'b1; exp_n = 0;
      m_flags = ld ? ldv : m_flags;
    end else begin
      bw = b; fw = m_flags; r = '0;
      for (int i = 0; i <= ec; i++) begin
        exp_b.push_back(bw);
        r = alu_f(op, cond, a, bw, fw);
        bw = r[16:5]; fw = r[4:0];
      end
      exp_q = r[16:5]; exp_sq = 1'b0; exp_n = ec + 1;
      m_flags = r[4:0];
    end
    check("in_ready_pre", in_ready, 1'b1);
    in_valid = 1'b1; in_op = op; in_cond = cond; in_a = a; in_b = b;
    in_count = cnt; in_pred = pred; flg_load = ld; flg_load_value = ldv;
    @(posedge clk); #1;
    in_valid = 1'b0; flg_load = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      check("alu_op", alu_op, op);
      if (n < exp_b.size()) check("alu_b", alu_b, exp_b[n]);
      n++;
      @(posedge clk); #1;
    end
    check("latency", n, exp_n);
    check("out_valid", out_valid, 1'b1);
    check("out_q", out_q, exp_q);
    check("squashed", out_squashed, exp_sq);
    check("flags", flags, m_flags);
    check("alu_op_idle", alu_op, 5'd0);
    check("in_ready_done", in_ready, 1'b0);
    q_hold = out_q; f_hold = flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_q", out_q, q_hold);
      check("hold_flags", flags, f_hold);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_cond = '0; in_a = '0; in_b = '0;
    in_count = '0; in_pred = 1'b0; out_ready = 1'b0; flg_load = 1'b0; flg_load_value = '0;
    m_flags = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_q", out_q, 12'd0);
    check("rst_squashed", out_squashed, 1'b0);
    check("rst_flags", flags, 5'd0);
    check("rst_alu_op", alu_op, 5'd0);

    run_op(5'h04, 4'h0, 12'h800, 12'h800, 4'd0, 1'b0, 1'b0, 5'd0, 0);
    check("add_flags_const", flags, 5'b01101);
    check("add_q_const", out_q, 12'h000);

    run_op(5'h0C, 4'h0, 12'h000, 12'h801, 4'd2, 1'b0, 1'b0, 5'd0, 0);
`ifdef ALU_REPEAT_EN
    check("shl_q_const", out_q, 12'h008);
`endif
    run_op(5'h09, 4'h0, 12'h000, 12'h123, 4'd11, 1'b0, 1'b0, 5'd0, 0);
`ifdef ALU_REPEAT_EN
    check("ror_q_const", out_q, 12'h123);
`endif
    run_op(5'h04, 4'h0, 12'h001, 12'h002, 4'd5, 1'b0, 1'b0, 5'd0, 0);
    check("add_single_const", out_q, 12'h003);

    run_op(5'h0C, 4'h0, 12'h000, 12'hFFF, 4'd15, 1'b0, 1'b0, 5'd0, 0);

    load_flags(5'b00000);
    run_op(5'h04, 4'h0, 12'h123, 12'h456, 4'd0, 1'b1, 1'b0, 5'd0, 0);
    check("squash_flags_const", flags, 5'b00000);
    check("squash_q_const", out_q, 12'h000);

    run_op(5'h03, 4'h0, 12'h010, 12'h020, 4'd0, 1'b0, 1'b0, 5'd0, 5);

    load_flags(5'b10000);
    run_op(5'h02, 4'h0, 12'h0F0, 12'h00F, 4'd0, 1'b1, 1'b1, 5'b00011, 0);
    check("preload_pred_sq", out_squashed, 1'b0);

    load_flags(5'b00000);
    run_op(5'h09, 4'h0, 12'h000, 12'h5A5, 4'd3, 1'b1, 1'b1, 5'b10110, 0);
    check("load_on_squash", flags, 5'b10110);

    in_valid = 1'b1; in_op = 5'h0C; in_cond = 4'h0; in_a = 12'h0; in_b = 12'h801;
    in_count = 4'd4; in_pred = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef ALU_REPEAT_EN
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_flags = '0;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_flags", flags, 5'd0);
    check("mid_rst_valid", out_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_valid", out_valid, 1'b0);
    end

    for (int t = 0; t < 60; t++) begin
      logic [4:0] op;
      logic ld;
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      ld = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) load_flags(5'($urandom));
      run_op(op, 4'($urandom), 12'($urandom), 12'($urandom), 4'($urandom),
             1'($urandom), ld, 5'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
